reg_file_wb_arbiter: RTL and testbench
======================================

# reg_file_wb_arbiter

Shares the single register-file write port between two writeback sources: the single-cycle ALU/jump writeback and the variable-latency memory load return. Load returns have priority. ALU writes that lose arbitration wait in a small FIFO. A starvation counter guarantees the ALU eventually gets the port. The block sits between the writeback stage and the register file, and drives its write-enable, write-address and write-data inputs from registered outputs.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- DEPTH, 2, ALU pending-write FIFO entries (power of 2, ≥2)
- STARVE_LIMIT, 3, consecutive load grants allowed while an ALU write is pending
- w_clock  in  1  clock; all state changes on rising edge
- w_reset_n  in  1  synchronous, active-low reset
- w_alu_valid  in  1  ALU/jump writeback request
- w_alu_addr  in  ADDR_W  ALU destination register
- w_alu_data  in  DATA_W  ALU result
- w_alu_ready  out  1  ALU request accepted this cycle when high with valid
- w_load_valid  in  1  load return request
- w_load_addr  in  ADDR_W  load destination register
- w_load_data  in  DATA_W  load data
- w_load_ready  out  1  load request accepted this cycle when high with valid
- w_query_addr_a, w_query_addr_b  in  ADDR_W  hazard lookup addresses
- w_pending_a, w_pending_b  out  1  queried register has an unretired write in the block
- w_en_out  out  1  register-file write enable (registered)
- w_waddr_out  out  ADDR_W  register-file write address (registered)
- w_wdata_out  out  DATA_W  register-file write data (registered)

## Operation
- Handshake: a transfer happens when valid & ready are both high at a rising edge. Requesters hold addr/data stable while valid is high and ready is low.
- w_alu_ready = (count < DEPTH) & w_reset_n. There is no same-cycle pop-through.
- w_load_ready = ~force_alu & w_reset_n, where force_alu = (starve_cnt == STARVE_LIMIT) & alu_cand.
- alu_cand = (count > 0) | (w_alu_valid & w_alu_ready & w_alu_addr != 0).
- Grant per cycle:
  - If force_alu: grant ALU.
  - Else if w_load_valid with nonzero address: grant load.
  - Else if alu_cand: grant ALU.
  - Else: idle.
- ALU grant source: FIFO head when count > 0. Otherwise the incoming request is bypassed and not pushed.
- Push: an accepted nonzero-address ALU request is pushed unless it was bypassed. Push and head pop in the same cycle leave count unchanged.
- Register 0: accepted requests with address 0 are discarded. They are never pushed, never granted, and never counted toward starvation. An address-0 load is still accepted (load_ready rules apply).
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) when load is granted while alu_cand is high.
  - Clears to 0 on any ALU grant.
  - Clears to 0 when alu_cand is low.
- Ordering: writes are in order within each source. Cross-source ordering to the same register is guaranteed by upstream hazard logic using w_pending_*.
- w_pending_x = (query != 0) & (a valid FIFO entry matches query, or w_en_out & w_waddr_out == query). Combinational.

## Timing
- Reset (w_reset_n low at an edge):
  - Outputs: w_en_out=0, w_waddr_out=0, w_wdata_out=0.
  - State: count=0, FIFO pointers=0, starve_cnt=0.
  - Both readys are 0 while w_reset_n is low. No transfer is accepted during reset.
- Reset mid-operation drops all FIFO contents and any granted write not yet presented.
- Latency: a request granted in cycle N appears on w_en_out/w_waddr_out/w_wdata_out in cycle N+1, for exactly one cycle.
  - ALU bypass or load: 1 cycle from acceptance.
  - FIFO entry: 1 cycle after its pop.
- w_en_out is 0 in any cycle following an idle grant.
- Full FIFO: w_alu_ready=0 while count==DEPTH. It rises the cycle after a pop.
- Throughput: one register-file write per cycle maximum.

## Test plan
- ALU only: after reset, ALU writes r3=0x11, r4=0x22 on back-to-back cycles. Expect w_en_out in cycles 1 and 2 with those values, count stays 0, w_alu_ready always 1.
- Collision: load r5=0xAA and ALU r6=0xBB valid in the same cycle. Expect r5 written at N+1, r6 pushed then written at N+2. w_pending_a (query 6) is high in N+1 and low in N+3.
- Starvation: continuous load stream to r7 with one pending ALU write r8=0x5. Expect exactly 3 load grants, then w_load_ready=0 for one cycle, r8 written, starve_cnt back to 0.
- Full FIFO: hold loads continuously and issue 3 ALU requests. Expect w_alu_ready=0 after 2 are accepted. After the forced ALU grant, the third is accepted one cycle later. All three are written in order.
- Register 0: ALU r0=0xFF and load r0=0xEE are both accepted. Expect w_en_out never asserted and w_pending (query 0) always 0.
- Reset mid-operation: with 2 FIFO entries pending, drive w_reset_n low for 1 cycle. Expect all outputs 0 and both readys 0 during reset, count 0 after, and no stale write ever emitted.

Source files
------------

// File: rtl/reg_file_wb_arbiter_if.sv
// Writeback-side bundle for the register-file write-port arbiter: ALU and
// load request channels, hazard queries, and the register-file write port.
interface reg_file_wb_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              w_alu_valid;
   logic [ADDR_W-1:0] w_alu_addr;
   logic [DATA_W-1:0] w_alu_data;
   logic              w_alu_ready;
   logic              w_load_valid;
   logic [ADDR_W-1:0] w_load_addr;
   logic [DATA_W-1:0] w_load_data;
   logic              w_load_ready;
   logic [ADDR_W-1:0] w_query_addr_a;
   logic [ADDR_W-1:0] w_query_addr_b;
   logic              w_pending_a;
   logic              w_pending_b;
   logic              w_en_out;
   logic [ADDR_W-1:0] w_waddr_out;
   logic [DATA_W-1:0] w_wdata_out;

   modport slave (
      input  w_alu_valid, w_alu_addr, w_alu_data,
      input  w_load_valid, w_load_addr, w_load_data,
      input  w_query_addr_a, w_query_addr_b,
      output w_alu_ready, w_load_ready, w_pending_a, w_pending_b,
      output w_en_out, w_waddr_out, w_wdata_out
   );

   modport master (
      output w_alu_valid, w_alu_addr, w_alu_data,
      output w_load_valid, w_load_addr, w_load_data,
      output w_query_addr_a, w_query_addr_b,
      input  w_alu_ready, w_load_ready, w_pending_a, w_pending_b,
      input  w_en_out, w_waddr_out, w_wdata_out
   );
endinterface

// File: rtl/reg_file_wb_arbiter.sv
// Arbitrates the single register-file write port between load returns (priority)
// and ALU writebacks (queued in a small FIFO, protected by a starvation counter).
module reg_file_wb_arbiter #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 3
) (
   input logic                  w_clock,
   input logic                  w_reset_n,
   reg_file_wb_arbiter_if.slave wb
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

   logic [ADDR_W-1:0] mem_addr [DEPTH];
   logic [DATA_W-1:0] mem_data [DEPTH];

   logic [CNT_W-1:0]  count_reg, count_next;
   logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
   logic [ST_W-1:0]   starve_reg, starve_next;
   logic              en_reg;
   logic [ADDR_W-1:0] waddr_reg;
   logic [DATA_W-1:0] wdata_reg;

   logic              fifo_nonempty;
   logic              alu_ready, alu_acc_nz, alu_cand, force_alu, load_ready;
   logic              grant_load, grant_alu, bypass, push, pop;
   logic [ADDR_W-1:0] alu_sel_addr;
   logic [DATA_W-1:0] alu_sel_data;
   logic [DEPTH-1:0]  match_a, match_b;

   assign fifo_nonempty = (count_reg != '0);
   assign alu_ready     = (count_reg < CNT_W'(DEPTH)) & w_reset_n;
   assign alu_acc_nz    = wb.w_alu_valid & alu_ready & (wb.w_alu_addr != '0);
   assign alu_cand      = fifo_nonempty | alu_acc_nz;
   assign force_alu     = (starve_reg == ST_W'(STARVE_LIMIT)) & alu_cand;
   assign load_ready    = ~force_alu & w_reset_n;

   // Address-0 loads are accepted through load_ready but never win the port.
   assign grant_load = load_ready & wb.w_load_valid & (wb.w_load_addr != '0);
   assign grant_alu  = w_reset_n & alu_cand & ~grant_load;
   assign bypass     = grant_alu & ~fifo_nonempty;
   assign push       = alu_acc_nz & ~bypass;
   assign pop        = grant_alu & fifo_nonempty;

   assign alu_sel_addr = fifo_nonempty ? mem_addr[rd_ptr_reg] : wb.w_alu_addr;
   assign alu_sel_data = fifo_nonempty ? mem_data[rd_ptr_reg] : wb.w_alu_data;

   always_comb begin
      count_next = count_reg;
      if (push && !pop) begin
         count_next = count_reg + CNT_W'(1);
      end else if (pop && !push) begin
         count_next = count_reg - CNT_W'(1);
      end
   end

   always_comb begin
      starve_next = starve_reg;
      if (!alu_cand || grant_alu) begin
         starve_next = '0;
      end else if (grant_load && starve_reg != ST_W'(STARVE_LIMIT)) begin
         starve_next = starve_reg + ST_W'(1);
      end
   end

   // An entry is live when its distance from the read pointer is below count.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      logic [PTR_W-1:0] offset;
      logic             live;
      assign offset      = PTR_W'(gi) - rd_ptr_reg;
      assign live        = ({1'b0, offset} < count_reg);
      assign match_a[gi] = live & (mem_addr[gi] == wb.w_query_addr_a);
      assign match_b[gi] = live & (mem_addr[gi] == wb.w_query_addr_b);
   end

   assign wb.w_pending_a = (wb.w_query_addr_a != '0) &
                           ((|match_a) | (en_reg & (waddr_reg == wb.w_query_addr_a)));
   assign wb.w_pending_b = (wb.w_query_addr_b != '0) &
                           ((|match_b) | (en_reg & (waddr_reg == wb.w_query_addr_b)));

   always_ff @(posedge w_clock) begin
      if (push) begin
         mem_addr[wr_ptr_reg] <= wb.w_alu_addr;
         mem_data[wr_ptr_reg] <= wb.w_alu_data;
      end
   end

   always_ff @(posedge w_clock) begin
      if (!w_reset_n) begin
         count_reg  <= '0;
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         starve_reg <= '0;
         en_reg     <= 1'b0;
         waddr_reg  <= '0;
         wdata_reg  <= '0;
      end else begin
         count_reg  <= count_next;
         starve_reg <= starve_next;
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         en_reg <= grant_alu | grant_load;
         if (grant_load) begin
            waddr_reg <= wb.w_load_addr;
            wdata_reg <= wb.w_load_data;
         end else if (grant_alu) begin
            waddr_reg <= alu_sel_addr;
            wdata_reg <= alu_sel_data;
         end
      end
   end

   assign wb.w_alu_ready  = alu_ready;
   assign wb.w_load_ready = load_ready;
   assign wb.w_en_out     = en_reg;
   assign wb.w_waddr_out  = waddr_reg;
   assign wb.w_wdata_out  = wdata_reg;
endmodule

// File: tb/tb_reg_file_wb_arbiter.sv
// Randomized bench for reg_file_wb_arbiter: a queue-based reference model predicts
// readys, hazard flags and the ordered stream of register-file writes.
module tb_reg_file_wb_arbiter;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 2;
   localparam int LIMIT  = 3;

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   reg_file_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   reg_file_wb_arbiter #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
   ) dut (
      .w_clock   (clk),
      .w_reset_n (rst_n),
      .wb        (bus.slave)
   );

   int  errors = 0;
   int  checks = 0;
   wr_t exp_q[$];
   wr_t alu_q[$];
   int  starve = 0;
   bit  last_en = 0;
   wr_t last_w;
   bit  prev_rn = 1;
   bit  started = 0;

   bit                cur_av = 0, cur_lv = 0, a_pend = 0, l_pend = 0;
   logic [ADDR_W-1:0] cur_aa = '0, cur_la = '0;
   logic [DATA_W-1:0] cur_ad = '0, cur_ld = '0;

   task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
      end
   endtask

   // Monitor: every presented write must be the next one the model predicted.
   always @(negedge clk) begin
      if (bus.w_en_out === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", 32'(bus.w_waddr_out), 32'hFFFF_FFFF);
         end else begin
            wr_t w;
            w = exp_q.pop_front();
            $display("write r%0d = %08h (expected r%0d = %08h)",
                     bus.w_waddr_out, bus.w_wdata_out, w.a, w.d);
            chk("write_addr", 32'(bus.w_waddr_out), 32'(w.a));
            chk("write_data", bus.w_wdata_out, w.d);
         end
      end
   end

   function automatic bit model_pending(input logic [ADDR_W-1:0] q);
      if (q == 0) return 0;
      if (last_en && last_w.a == q) return 1;
      foreach (alu_q[i]) if (alu_q[i].a == q) return 1;
      return 0;
   endfunction

   task automatic step(input bit rn,
                       input bit av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                       input bit lv, input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld,
                       output bit a_acc, output bit l_acc);
      int  qs;
      bit  exp_ar, exp_lr, acc_nz, cand, frc, gload, galu;
      wr_t inc, ldw, w;
      @(posedge clk);
      #1;
      if (!prev_rn) begin
         chk("reset_en", 32'(bus.w_en_out), 32'd0);
         chk("reset_waddr", 32'(bus.w_waddr_out), 32'd0);
         chk("reset_wdata", bus.w_wdata_out, 32'd0);
      end
      rst_n = rn;
      bus.w_alu_valid = av; bus.w_alu_addr = aa; bus.w_alu_data = ad;
      bus.w_load_valid = lv; bus.w_load_addr = la; bus.w_load_data = ld;
      bus.w_query_addr_a = ADDR_W'($urandom_range(0, 7));
      bus.w_query_addr_b = ADDR_W'($urandom_range(0, 7));
      #1;
      qs     = alu_q.size();
      exp_ar = rn && (qs < DEPTH);
      acc_nz = av && exp_ar && (aa != 0);
      cand   = (qs > 0) || acc_nz;
      frc    = (starve == LIMIT) && cand;
      exp_lr = rn && !frc;
      chk("alu_ready", 32'(bus.w_alu_ready), 32'(exp_ar));
      chk("load_ready", 32'(bus.w_load_ready), 32'(exp_lr));
      if (started && rn) begin
         chk("pending_a", 32'(bus.w_pending_a), 32'(model_pending(bus.w_query_addr_a)));
         chk("pending_b", 32'(bus.w_pending_b), 32'(model_pending(bus.w_query_addr_b)));
      end
      inc.a = aa; inc.d = ad;
      ldw.a = la; ldw.d = ld;
      w = inc;
      gload = exp_lr && lv && (la != 0);
      galu  = rn && cand && !gload;
      if (galu) begin
         if (qs > 0) begin
            w = alu_q.pop_front();
            if (acc_nz) alu_q.push_back(inc);
         end
         exp_q.push_back(w);
      end else if (gload) begin
         w = ldw;
         exp_q.push_back(w);
         if (acc_nz) alu_q.push_back(inc);
      end
      if (!rn || !cand || galu) starve = 0;
      else if (gload && starve < LIMIT) starve++;
      if (!rn) alu_q.delete();
      last_en = galu || gload;
      last_w  = w;
      prev_rn = rn;
      started = 1;
      a_acc = av && exp_ar;
      l_acc = lv && exp_lr;
   endtask

   function automatic logic [ADDR_W-1:0] rand_addr(input int p_zero);
      if (int'($urandom_range(0, 99)) < p_zero) return '0;
      return ADDR_W'($urandom_range(1, 7));
   endfunction

   // Requesters hold addr/data while valid and not yet accepted.
   task automatic run(input int n, input int p_alu, input int p_load,
                      input int p_zero, input int p_rst);
      bit rn, a_acc, l_acc;
      for (int i = 0; i < n; i++) begin
         if (!a_pend) begin
            cur_av = int'($urandom_range(0, 99)) < p_alu;
            cur_aa = rand_addr(p_zero);
            cur_ad = $urandom;
         end
         if (!l_pend) begin
            cur_lv = int'($urandom_range(0, 99)) < p_load;
            cur_la = rand_addr(p_zero);
            cur_ld = $urandom;
         end
         rn = !(int'($urandom_range(0, 99)) < p_rst);
         step(rn, cur_av, cur_aa, cur_ad, cur_lv, cur_la, cur_ld, a_acc, l_acc);
         a_pend = cur_av && !a_acc;
         l_pend = cur_lv && !l_acc;
      end
   endtask

   task automatic drain();
      bit a_acc, l_acc;
      for (int i = 0; i < 8; i++) begin
         step(1, 0, '0, '0, 0, '0, '0, a_acc, l_acc);
      end
      a_pend = 0;
      l_pend = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit a_acc, l_acc;
      bus.w_alu_valid = 0; bus.w_alu_addr = '0; bus.w_alu_data = '0;
      bus.w_load_valid = 0; bus.w_load_addr = '0; bus.w_load_data = '0;
      bus.w_query_addr_a = '0; bus.w_query_addr_b = '0;
      step(0, 0, '0, '0, 0, '0, '0, a_acc, l_acc);
      step(0, 1, 5'd3, 32'h1, 1, 5'd4, 32'h2, a_acc, l_acc);
      // Directed: back-to-back ALU, collision, then register 0 on both sources.
      step(1, 1, 5'd3, 32'h11, 0, '0, '0, a_acc, l_acc);
      step(1, 1, 5'd4, 32'h22, 0, '0, '0, a_acc, l_acc);
      step(1, 1, 5'd6, 32'hBB, 1, 5'd5, 32'hAA, a_acc, l_acc);
      step(1, 0, '0, '0, 0, '0, '0, a_acc, l_acc);
      step(1, 1, 5'd0, 32'hFF, 1, 5'd0, 32'hEE, a_acc, l_acc);
      // Directed starvation: one ALU write against a continuous load stream.
      step(1, 1, 5'd8, 32'h5, 1, 5'd7, 32'h70, a_acc, l_acc);
      for (int i = 1; i < 6; i++) begin
         step(1, 0, '0, '0, 1, 5'd7, 32'(32'h70 + i), a_acc, l_acc);
      end
      drain();
      run(200, 70, 0, 10, 0);
      drain();
      run(300, 60, 100, 10, 0);
      drain();
      run(300, 50, 60, 40, 0);
      drain();
      run(400, 70, 90, 10, 3);
      drain();
      run(300, 40, 40, 15, 0);
      drain();
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
